// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns a stream of received PS/2 set-2 scan-code bytes into key events.
//   It understands the E0 (extended) and F0 (release) prefixes and the
//   8-byte E1 Pause sequence. It drops controller responses seen in IDLE and,
//   optionally, the E0 12 / E0 59 fake-shift codes. A partial prefix is
//   abandoned after TIMEOUT_CYCLES idle cycles.
//
// Ports
//   clk_sys    in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   code_valid in   1   one-cycle strobe: code_data/code_err hold a byte
//   code_data  in   8   received scan-code byte
//   code_err   in   1   parity/framing error, qualified by code_valid
//   ps2_key    out 11   [7:0] code, [8] extended, [9] pressed, [10] toggle
//   key_event  out  1   one-cycle pulse with every ps2_key update
//   busy       out  1   decoder is inside a multi-byte sequence
//   err_count  out  8   saturating count of bad bytes and timeouts
module ps2_key_decoder #(
  parameter logic [23:0] TIMEOUT_CYCLES    = 24'd2400000,
  parameter logic [7:0]  PAUSE_CODE        = 8'h77,
  parameter int unsigned FILTER_FAKE_SHIFT = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        code_valid,
  input  logic [7:0]  code_data,
  input  logic        code_err,
  output logic [10:0] ps2_key,
  output logic        key_event,
  output logic        busy,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    REL,
    EXTREL,
    PAUSE
  } state_t;

  localparam logic [23:0] TO_LAST = TIMEOUT_CYCLES - 24'd1;

  state_t      r_state;
  logic [2:0]  r_pause_cnt;
  logic [23:0] r_to_cnt;
  logic [10:0] r_ps2_key;
  logic        r_key_event;
  logic [7:0]  r_err_count;

  logic w_is_resp;
  logic w_is_fake;
  logic w_ext;
  logic w_pressed;

  // Controller responses that must never be decoded as keys in IDLE.
  assign w_is_resp = (code_data == 8'hAA) || (code_data == 8'hFA) ||
                     (code_data == 8'hFE) || (code_data == 8'hEE) ||
                     (code_data == 8'h00);

  assign w_is_fake = (FILTER_FAKE_SHIFT != 0) &&
                     ((code_data == 8'h12) || (code_data == 8'h59)) &&
                     ((r_state == EXT) || (r_state == EXTREL));

  assign w_ext     = (r_state == EXT) || (r_state == EXTREL);
  assign w_pressed = (r_state == IDLE) || (r_state == EXT);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pause_cnt <= 3'd0;
      r_to_cnt    <= 24'd0;
      r_ps2_key   <= 11'h000;
      r_key_event <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      r_key_event <= 1'b0;
      if (code_valid) begin
        // A strobe always wins over a timeout expiring in the same cycle.
        r_to_cnt <= 24'd0;
        if (code_err) begin
          r_state     <= IDLE;
          r_pause_cnt <= 3'd0;
          if (r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
          end
        end else if (r_state == PAUSE) begin
          // Pause bytes are counted blindly; the E1 itself was byte 1.
          if (r_pause_cnt == 3'd7) begin
            r_ps2_key   <= {~r_ps2_key[10], 1'b1, 1'b1, PAUSE_CODE};
            r_key_event <= 1'b1;
            r_state     <= IDLE;
            r_pause_cnt <= 3'd0;
          end else begin
            r_pause_cnt <= r_pause_cnt + 3'd1;
          end
        end else if (code_data == 8'hE0) begin
          r_state <= EXT;
        end else if (code_data == 8'hF0) begin
          // REL and EXTREL keep their state on a repeated F0.
          if (r_state == IDLE) begin
            r_state <= REL;
          end else if (r_state == EXT) begin
            r_state <= EXTREL;
          end
        end else if (code_data == 8'hE1) begin
          r_state     <= PAUSE;
          r_pause_cnt <= 3'd1;
        end else if ((r_state == IDLE) && w_is_resp) begin
          r_state <= IDLE;
        end else if (w_is_fake) begin
          r_state <= IDLE;
        end else begin
          r_ps2_key   <= {~r_ps2_key[10], w_pressed, w_ext, code_data};
          r_key_event <= 1'b1;
          r_state     <= IDLE;
        end
      end else if (r_state != IDLE) begin
        if (r_to_cnt == TO_LAST) begin
          r_state     <= IDLE;
          r_pause_cnt <= 3'd0;
          r_to_cnt    <= 24'd0;
          if (r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
          end
        end else begin
          r_to_cnt <= r_to_cnt + 24'd1;
        end
      end
    end
  end

  assign ps2_key   = r_ps2_key;
  assign key_event = r_key_event;
  assign busy      = (r_state != IDLE);
  assign err_count = r_err_count;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of byte sequences with
// hand-computed key events, plus hand-written sequences for pause, errors,
// timeout, strobe/timeout priority, back-to-back strobes, reset and
// err_count saturation.
module tb_ps2_key_decoder;

  localparam int TO = 20;
  localparam int NV = 16;

  logic        clk_sys;
  logic        reset_n;
  logic        code_valid;
  logic [7:0]  code_data;
  logic        code_err;
  logic [10:0] ps2_key;
  logic        key_event;
  logic        busy;
  logic [7:0]  err_count;

  int n_checks;
  int n_pass;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES   (24'd20),
    .PAUSE_CODE       (8'h77),
    .FILTER_FAKE_SHIFT(1)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .code_valid(code_valid),
    .code_data (code_data),
    .code_err  (code_err),
    .ps2_key   (ps2_key),
    .key_event (key_event),
    .busy      (busy),
    .err_count (err_count)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          n;
    logic [63:0] bytes;     // byte 0 in bits [7:0]
    bit          exp_ev;
    logic [9:0]  exp_key;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe one byte; returns key_event as seen after the processing edge.
  task automatic send_byte(input logic [7:0] b, input logic e, output logic ev);
    @(negedge clk_sys);
    code_valid = 1'b1;
    code_data  = b;
    code_err   = e;
    @(negedge clk_sys);
    code_valid = 1'b0;
    code_err   = 1'b0;
    ev = key_event;
  endtask

  logic       ev;
  int         ev_cnt;
  logic       exp_tog;
  logic [9:0] exp_last;

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    code_valid = 1'b0;
    code_data  = 8'h00;
    code_err   = 1'b0;
    exp_tog    = 1'b0;
    exp_last   = 10'h000;

    vecs[0]  = '{1, 64'h1C,               1'b1, 10'h21C, 1'b0};
    vecs[1]  = '{2, 64'h1CF0,             1'b1, 10'h01C, 1'b0};
    vecs[2]  = '{2, 64'h75E0,             1'b1, 10'h375, 1'b0};
    vecs[3]  = '{3, 64'h75F0E0,           1'b1, 10'h175, 1'b0};
    vecs[4]  = '{2, 64'h12E0,             1'b0, 10'h000, 1'b0};
    vecs[5]  = '{3, 64'h59F0E0,           1'b0, 10'h000, 1'b0};
    vecs[6]  = '{2, 64'h59E0,             1'b0, 10'h000, 1'b0};
    vecs[7]  = '{1, 64'hAA,               1'b0, 10'h000, 1'b0};
    vecs[8]  = '{1, 64'hFA,               1'b0, 10'h000, 1'b0};
    vecs[9]  = '{1, 64'h00,               1'b0, 10'h000, 1'b0};
    vecs[10] = '{1, 64'hFE,               1'b0, 10'h000, 1'b0};
    vecs[11] = '{2, 64'hAAF0,             1'b1, 10'h0AA, 1'b0};
    vecs[12] = '{3, 64'h1CE0F0,           1'b1, 10'h31C, 1'b0};
    vecs[13] = '{3, 64'h1CF0F0,           1'b1, 10'h01C, 1'b0};
    vecs[14] = '{1, 64'hF0,               1'b0, 10'h000, 1'b1};
    vecs[15] = '{1, 64'h12,               1'b1, 10'h012, 1'b0};

    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst_key",   32'(ps2_key),   32'h000);
    check("rst_event", 32'(key_event), 32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_err",   32'(err_count), 32'h00);
    reset_n = 1'b1;

    // Table-driven sequences (vector 14 leaves REL pending, vector 15 releases 12)
    for (int v = 0; v < NV; v++) begin
      ev_cnt = 0;
      ev = 1'b0;
      for (int i = 0; i < vecs[v].n; i++) begin
        send_byte(vecs[v].bytes[8*i +: 8], 1'b0, ev);
        if (ev) ev_cnt++;
      end
      if (vecs[v].exp_ev) begin
        exp_tog  = ~exp_tog;
        exp_last = vecs[v].exp_key;
      end
      check($sformatf("v%0d_nevents", v), 32'(ev_cnt), vecs[v].exp_ev ? 32'd1 : 32'd0);
      check($sformatf("v%0d_lastev", v),  32'(ev),     32'(vecs[v].exp_ev));
      check($sformatf("v%0d_key", v),     32'(ps2_key), 32'({exp_tog, exp_last}));
      check($sformatf("v%0d_busy", v),    32'(busy),    32'(vecs[v].exp_busy));
      @(negedge clk_sys);
      check($sformatf("v%0d_pulse_end", v), 32'(key_event), 32'h0);
    end

    // Pause sequence: busy through bytes 1..7, single event after byte 8
    begin
      logic [63:0] pseq;
      pseq = 64'h77F014F0E17714E1;
      for (int i = 0; i < 8; i++) begin
        send_byte(pseq[8*i +: 8], 1'b0, ev);
        if (i < 7) begin
          check($sformatf("pause_b%0d_busy", i + 1), 32'(busy), 32'h1);
          check($sformatf("pause_b%0d_ev", i + 1),   32'(ev),   32'h0);
        end
      end
      exp_tog  = ~exp_tog;
      exp_last = 10'h377;
      check("pause_ev",   32'(ev),      32'h1);
      check("pause_key",  32'(ps2_key), 32'({exp_tog, exp_last}));
      check("pause_busy", 32'(busy),    32'h0);
    end

    // Errored F0 is discarded
    send_byte(8'hF0, 1'b1, ev);
    check("err_ev",   32'(ev),        32'h0);
    check("err_cnt",  32'(err_count), 32'h01);
    check("err_busy", 32'(busy),      32'h0);

    // E0 then silence: abandoned after TO idle cycles
    send_byte(8'hE0, 1'b0, ev);
    repeat (TO - 1) @(negedge clk_sys);
    check("to_busy_before", 32'(busy),      32'h1);
    check("to_err_before",  32'(err_count), 32'h01);
    @(negedge clk_sys);
    check("to_busy_after",  32'(busy),      32'h0);
    check("to_err_after",   32'(err_count), 32'h02);
    check("to_key_same",    32'(ps2_key),   32'({exp_tog, exp_last}));

    // Strobe lands on the cycle the timeout would fire: byte wins
    send_byte(8'hE0, 1'b0, ev);
    repeat (TO - 2) @(negedge clk_sys);
    send_byte(8'h75, 1'b0, ev);
    exp_tog  = ~exp_tog;
    exp_last = 10'h375;
    check("prio_ev",  32'(ev),        32'h1);
    check("prio_key", 32'(ps2_key),   32'({exp_tog, exp_last}));
    check("prio_err", 32'(err_count), 32'h02);

    // Back-to-back strobes: E0 F0 75 1C on consecutive cycles
    @(negedge clk_sys);
    code_valid = 1'b1;
    code_data  = 8'hE0;
    @(negedge clk_sys);
    code_data  = 8'hF0;
    @(negedge clk_sys);
    code_data  = 8'h75;
    @(negedge clk_sys);
    code_data  = 8'h1C;
    exp_tog  = ~exp_tog;
    exp_last = 10'h175;
    check("b2b_ev1",  32'(key_event), 32'h1);
    check("b2b_key1", 32'(ps2_key),   32'({exp_tog, exp_last}));
    @(negedge clk_sys);
    code_valid = 1'b0;
    exp_tog  = ~exp_tog;
    exp_last = 10'h21C;
    check("b2b_ev2",  32'(key_event), 32'h1);
    check("b2b_key2", 32'(ps2_key),   32'({exp_tog, exp_last}));

    // Reset between E0 and 75
    send_byte(8'hE0, 1'b0, ev);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check("mid_rst_key",  32'(ps2_key),   32'h000);
    check("mid_rst_busy", 32'(busy),      32'h0);
    check("mid_rst_err",  32'(err_count), 32'h00);
    @(negedge clk_sys);
    reset_n  = 1'b1;
    exp_tog  = 1'b1;
    exp_last = 10'h275;
    send_byte(8'h75, 1'b0, ev);
    check("post_rst_ev",  32'(ev),      32'h1);
    check("post_rst_key", 32'(ps2_key), 32'({exp_tog, exp_last}));

    // err_count saturation
    for (int i = 0; i < 254; i++) send_byte(8'h1C, 1'b1, ev);
    check("sat_254", 32'(err_count), 32'hFE);
    send_byte(8'h1C, 1'b1, ev);
    check("sat_255", 32'(err_count), 32'hFF);
    send_byte(8'h1C, 1'b1, ev);
    check("sat_hold", 32'(err_count), 32'hFF);
    check("sat_key",  32'(ps2_key),   32'({exp_tog, exp_last}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
